// File: rtl/sdram_port_arb.sv
// Two-requester Avalon-MM arbiter in front of a single SDRAM controller port.
// Write bursts lock the grant; read data is steered back through an in-order id FIFO.
module sdram_port_arb #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int BC_W     = 8,
  parameter int RD_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [ADDR_W-1:0]         m0_address_i,
  input  logic [BC_W-1:0]           m0_burstcount_i,
  input  logic                      m0_write_i,
  input  logic                      m0_read_i,
  input  logic [DATA_W-1:0]         m0_writedata_i,
  input  logic [DATA_W/8-1:0]       m0_byteenable_i,
  output logic                      m0_waitrequest_o,
  output logic [DATA_W-1:0]         m0_readdata_o,
  output logic                      m0_readdatavalid_o,
  input  logic [ADDR_W-1:0]         m1_address_i,
  input  logic [BC_W-1:0]           m1_burstcount_i,
  input  logic                      m1_write_i,
  input  logic                      m1_read_i,
  input  logic [DATA_W-1:0]         m1_writedata_i,
  input  logic [DATA_W/8-1:0]       m1_byteenable_i,
  output logic                      m1_waitrequest_o,
  output logic [DATA_W-1:0]         m1_readdata_o,
  output logic                      m1_readdatavalid_o,
  output logic [ADDR_W-1:0]         s_address_o,
  output logic [BC_W-1:0]           s_burstcount_o,
  output logic                      s_write_o,
  output logic                      s_read_o,
  output logic [DATA_W-1:0]         s_writedata_o,
  output logic [DATA_W/8-1:0]       s_byteenable_o,
  input  logic                      s_waitrequest_i,
  input  logic [DATA_W-1:0]         s_readdata_i,
  input  logic                      s_readdatavalid_i,
  output logic [$clog2(RD_DEPTH):0] rd_outstanding_o,
  output logic                      err_o
);

  localparam int CW = $clog2(RD_DEPTH) + 1;
  localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, CMD, WBURST} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic [BC_W-1:0] beatsLeft_q, beatsLeft_d;
  logic [BC_W-1:0] retCnt_q, retCnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic            fifoId_q [RD_DEPTH];
  logic [BC_W-1:0] fifoBc_q [RD_DEPTH];
  logic            err_q;

  logic            m0Req, m1Req;
  logic            gWr, gRd, gWait, readGo, push, pop;
  logic [BC_W-1:0] gBc, gBcEff, headBc;
  logic            headId, fifoFull, fifoEmpty, retValid;

  assign m0Req  = m0_write_i | m0_read_i;
  assign m1Req  = m1_write_i | m1_read_i;
  assign gWr    = grant_q ? m1_write_i : m0_write_i;
  assign gRd    = grant_q ? m1_read_i : m0_read_i;
  assign gBc    = grant_q ? m1_burstcount_i : m0_burstcount_i;
  assign gBcEff = (gBc == '0) ? BC_W'(1) : gBc;

  assign s_address_o    = grant_q ? m1_address_i : m0_address_i;
  assign s_burstcount_o = gBc;
  assign s_writedata_o  = grant_q ? m1_writedata_i : m0_writedata_i;
  assign s_byteenable_o = grant_q ? m1_byteenable_i : m0_byteenable_i;

  assign fifoFull  = (count_q == CW'(RD_DEPTH));
  assign fifoEmpty = (count_q == '0);
  assign readGo    = gRd && !gWr && !fifoFull;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    beatsLeft_d = beatsLeft_q;
    s_write_o   = 1'b0;
    s_read_o    = 1'b0;
    gWait       = 1'b1;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0Req || m1Req) begin
          grant_d = (m0Req && m1Req) ? prio_q : m1Req;
          state_d = CMD;
        end
      end
      CMD: begin
        s_write_o = gWr;
        s_read_o  = readGo;
        // A read stalled by a full return FIFO is held off locally, not at the slave.
        gWait     = (gRd && !gWr && fifoFull) ? 1'b1 : s_waitrequest_i;
        if (gWr && !s_waitrequest_i) begin
          if (gBcEff == BC_W'(1)) begin
            prio_d  = ~grant_q;
            state_d = IDLE;
          end else begin
            beatsLeft_d = gBcEff - 1'b1;
            state_d     = WBURST;
          end
        end else if (readGo && !s_waitrequest_i) begin
          push    = 1'b1;
          prio_d  = ~grant_q;
          state_d = IDLE;
        end else if (!gWr && !gRd) begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        s_write_o = gWr;
        gWait     = s_waitrequest_i;
        if (gWr && !s_waitrequest_i) begin
          beatsLeft_d = beatsLeft_q - 1'b1;
          if (beatsLeft_q == BC_W'(1)) begin
            prio_d  = ~grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_waitrequest_o = grant_q ? 1'b1 : gWait;
  assign m1_waitrequest_o = grant_q ? gWait : 1'b1;

  assign headId   = fifoId_q[rdPtr_q];
  assign headBc   = fifoBc_q[rdPtr_q];
  assign retValid = s_readdatavalid_i && !fifoEmpty;
  assign pop      = retValid && (retCnt_q == headBc - 1'b1);

  assign m0_readdata_o      = s_readdata_i;
  assign m1_readdata_o      = s_readdata_i;
  assign m0_readdatavalid_o = retValid && !headId;
  assign m1_readdatavalid_o = retValid && headId;

  always_comb begin
    retCnt_d = retCnt_q;
    count_d  = count_q;
    if (retValid) retCnt_d = pop ? '0 : retCnt_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      beatsLeft_q <= '0;
      retCnt_q    <= '0;
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      beatsLeft_q <= beatsLeft_d;
      retCnt_q    <= retCnt_d;
      count_q     <= count_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      if (s_readdatavalid_i && fifoEmpty) err_q <= 1'b1;
    end
  end

  // Entry payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoId_q[wrPtr_q] <= grant_q;
      fifoBc_q[wrPtr_q] <= gBcEff;
    end
  end

  assign rd_outstanding_o = count_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: directed scenarios pinned with literal
// expectations, then randomized Avalon traffic compared against a queue-based model.
module tb_sdram_port_arb;

  localparam int ADDR_W   = 28;
  localparam int DATA_W   = 32;
  localparam int BC_W     = 8;
  localparam int RD_DEPTH = 4;
  localparam int BE_W     = DATA_W / 8;
  localparam int OW       = $clog2(RD_DEPTH) + 1;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] mAddr [2];
  logic [BC_W-1:0]   mBc [2];
  logic [DATA_W-1:0] mWd [2];
  logic [BE_W-1:0]   mBe [2];
  logic [1:0]        mWr, mRd;
  logic              sWait, sRdv;
  logic [DATA_W-1:0] sRdata;

  logic              m0Wait, m1Wait, m0Rdv, m1Rdv, sWr, sRd, errO;
  logic [DATA_W-1:0] m0Rdata, m1Rdata, sWd;
  logic [ADDR_W-1:0] sAddr;
  logic [BC_W-1:0]   sBc;
  logic [BE_W-1:0]   sBe;
  logic [OW-1:0]     rdOut;

  sdram_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BC_W(BC_W), .RD_DEPTH(RD_DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rstN),
    .m0_address_i(mAddr[0]), .m0_burstcount_i(mBc[0]), .m0_write_i(mWr[0]), .m0_read_i(mRd[0]),
    .m0_writedata_i(mWd[0]), .m0_byteenable_i(mBe[0]), .m0_waitrequest_o(m0Wait),
    .m0_readdata_o(m0Rdata), .m0_readdatavalid_o(m0Rdv),
    .m1_address_i(mAddr[1]), .m1_burstcount_i(mBc[1]), .m1_write_i(mWr[1]), .m1_read_i(mRd[1]),
    .m1_writedata_i(mWd[1]), .m1_byteenable_i(mBe[1]), .m1_waitrequest_o(m1Wait),
    .m1_readdata_o(m1Rdata), .m1_readdatavalid_o(m1Rdv),
    .s_address_o(sAddr), .s_burstcount_o(sBc), .s_write_o(sWr), .s_read_o(sRd),
    .s_writedata_o(sWd), .s_byteenable_o(sBe), .s_waitrequest_i(sWait),
    .s_readdata_i(sRdata), .s_readdatavalid_i(sRdv),
    .rd_outstanding_o(rdOut), .err_o(errO)
  );

  int testsRun = 0;
  int testsFailed = 0;
  bit checking = 0;

  // Reference model: who is being presented, how many burst beats remain, and
  // a queue of (requester, beats still to return) for each accepted read.
  bit presenting;
  int owner, burstLeft, favour;
  int qId[$];
  int qBeats[$];
  bit errExp;

  bit expSWr, expSRd;
  bit [1:0] expW, expRdv, acc;

  logic smpSWr, smpSRd, smpW0, smpW1, smpRdv0, smpRdv1, smpErr;
  logic [OW-1:0] smpOut;
  logic [ADDR_W-1:0] smpAddr;
  logic [DATA_W-1:0] smpRdata0;

  int nAcc, beats, who, slavePend;
  int mode [2];
  int wLeft [2];
  bit firstDone [2];

  function automatic int bcEff(logic [BC_W-1:0] b);
    return (b == '0) ? 1 : int'(b);
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic computeExpected();
    expSWr = 0; expSRd = 0; expW = 2'b11; expRdv = 2'b00;
    if (presenting) begin
      if (burstLeft > 0) begin
        expSWr = mWr[owner];
        expW[owner] = sWait;
      end else if (mWr[owner]) begin
        expSWr = 1;
        expW[owner] = sWait;
      end else if (mRd[owner]) begin
        if (qId.size() == RD_DEPTH) expW[owner] = 1;
        else begin
          expSRd = 1;
          expW[owner] = sWait;
        end
      end else expW[owner] = sWait;
    end
    if (sRdv && qId.size() > 0) expRdv[qId[0]] = 1;
  endtask

  task automatic checkAll();
    checkOutput("s_write", sWr, expSWr);
    checkOutput("s_read", sRd, expSRd);
    checkOutput("m0_waitrequest", m0Wait, expW[0]);
    checkOutput("m1_waitrequest", m1Wait, expW[1]);
    checkOutput("m0_readdatavalid", m0Rdv, expRdv[0]);
    checkOutput("m1_readdatavalid", m1Rdv, expRdv[1]);
    checkOutput("rd_outstanding", rdOut, qId.size());
    checkOutput("err", errO, errExp);
    checkOutput("m0_readdata", m0Rdata, sRdata);
    checkOutput("m1_readdata", m1Rdata, sRdata);
    if (presenting) begin
      checkOutput("s_address", sAddr, mAddr[owner]);
      checkOutput("s_burstcount", sBc, mBc[owner]);
      checkOutput("s_writedata", sWd, mWd[owner]);
      checkOutput("s_byteenable", sBe, mBe[owner]);
    end
  endtask

  task automatic updateModel();
    int n;
    if (!rstN) begin
      presenting = 0; owner = 0; burstLeft = 0; favour = 0; errExp = 0;
      qId.delete(); qBeats.delete();
      return;
    end
    if (sRdv) begin
      if (qId.size() == 0) errExp = 1;
      else begin
        qBeats[0]--;
        if (qBeats[0] == 0) begin
          void'(qId.pop_front());
          void'(qBeats.pop_front());
        end
      end
    end
    n = bcEff(mBc[owner]);
    if (presenting) begin
      if (burstLeft > 0) begin
        if (expSWr && !sWait) begin
          burstLeft--;
          if (burstLeft == 0) begin presenting = 0; favour = 1 - owner; end
        end
      end else if (expSWr && !sWait) begin
        if (n == 1) begin presenting = 0; favour = 1 - owner; end
        else burstLeft = n - 1;
      end else if (expSRd && !sWait) begin
        qId.push_back(owner);
        qBeats.push_back(n);
        presenting = 0;
        favour = 1 - owner;
      end else if (!mWr[owner] && !mRd[owner]) presenting = 0;
    end else if (mWr != 2'b00 || mRd != 2'b00) begin
      presenting = 1;
      if ((mWr[0] | mRd[0]) && (mWr[1] | mRd[1])) owner = favour;
      else owner = (mWr[1] | mRd[1]) ? 1 : 0;
    end
  endtask

  // One clock: inputs are already driven; sample mid-cycle, then let the edge happen.
  task automatic applyStimulus();
    #4;
    computeExpected();
    smpSWr = sWr; smpSRd = sRd; smpW0 = m0Wait; smpW1 = m1Wait;
    smpRdv0 = m0Rdv; smpRdv1 = m1Rdv; smpErr = errO; smpOut = rdOut;
    smpAddr = sAddr; smpRdata0 = m0Rdata;
    if (checking) checkAll();
    for (int k = 0; k < 2; k++) acc[k] = (mWr[k] | mRd[k]) & ~expW[k];
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idleInputs();
    mWr = 2'b00; mRd = 2'b00; sWait = 0; sRdv = 0; sRdata = '0;
    for (int k = 0; k < 2; k++) begin
      mAddr[k] = '0; mBc[k] = BC_W'(1); mWd[k] = '0; mBe[k] = '1;
    end
  endtask

  task automatic doReset();
    idleInputs();
    rstN = 0;
    applyStimulus();
    rstN = 1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    presenting = 0; owner = 0; burstLeft = 0; favour = 0; errExp = 0;
    doReset();
    checking = 1;
    doReset();

    // Reset state
    applyStimulus();
    checkOutput("rst_s_write", smpSWr, 0);
    checkOutput("rst_s_read", smpSRd, 0);
    checkOutput("rst_m0_wait", smpW0, 1);
    checkOutput("rst_m1_wait", smpW1, 1);
    checkOutput("rst_outstanding", smpOut, 0);
    checkOutput("rst_err", smpErr, 0);

    // Both write bc=1 forever: grants alternate, one beat per two cycles
    doReset();
    mWr = 2'b11; mAddr[0] = 'h100; mAddr[1] = 'h200; nAcc = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (i == 0) checkOutput("s1_first_idle", smpSWr, 0);
      if (smpSWr && (!smpW0 || !smpW1)) begin
        who = smpW0 ? 1 : 0;
        checkOutput("s1_grant_order", who, nAcc % 2);
        checkOutput("s1_addr", smpAddr, (nAcc % 2) ? 'h200 : 'h100);
        checkOutput("s1_accept_phase", i % 2, 1);
        nAcc++;
      end
    end
    checkOutput("s1_accept_count", nAcc, 6);

    // m0 bc=4 write burst holds off m1's read until the 4th beat
    doReset();
    mWr = 2'b01; mRd = 2'b10; mBc[0] = 4; mAddr[0] = 'h300; mAddr[1] = 'h400; beats = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
      if (i >= 1 && i <= 4) checkOutput("s2_burst_beat", smpSWr, 1);
      if (i <= 5) checkOutput("s2_m1_held", smpW1, 1);
      if (smpSWr && !smpW0) beats++;
      if (beats == 4) mWr[0] = 0;
      if (i == 6) begin
        checkOutput("s2_m1_read_issued", smpSRd, 1);
        checkOutput("s2_m1_read_addr", smpAddr, 'h400);
        checkOutput("s2_m1_wait_low", smpW1, 0);
        mRd[1] = 0;
      end
    end
    checkOutput("s2_beats", beats, 4);
    sRdv = 1; sRdata = 'h55AA;
    applyStimulus();
    checkOutput("s2_rdv_m1", smpRdv1, 1);
    checkOutput("s2_rdv_m0", smpRdv0, 0);
    sRdv = 0;

    // m1 reads bc=2, then m0 reads bc=3; five return beats are split 2/3
    doReset();
    mRd = 2'b10; mBc[1] = 2; mAddr[1] = 'h500;
    applyStimulus();
    applyStimulus();
    checkOutput("s3_m1_read", smpSRd, 1);
    mRd = 2'b01; mBc[0] = 3; mAddr[0] = 'h600;
    applyStimulus();
    checkOutput("s3_out_1", smpOut, 1);
    applyStimulus();
    checkOutput("s3_m0_read", smpSRd, 1);
    mRd = 2'b00; sRdv = 1;
    for (int b = 1; b <= 5; b++) begin
      sRdata = DATA_W'(32'hA000 + b);
      applyStimulus();
      if (b == 1) checkOutput("s3_out_2", smpOut, 2);
      if (b == 3) checkOutput("s3_out_back_1", smpOut, 1);
      checkOutput("s3_rdv_m1", smpRdv1, b <= 2);
      checkOutput("s3_rdv_m0", smpRdv0, b >= 3);
      checkOutput("s3_data_m0", smpRdata0, 32'hA000 + b);
    end
    sRdv = 0;
    applyStimulus();
    checkOutput("s3_out_0", smpOut, 0);

    // Four reads fill the FIFO; the fifth waits for the first pop
    doReset();
    mRd = 2'b01; mAddr[0] = 'h700; nAcc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      if (smpSRd && !smpW0) nAcc++;
    end
    checkOutput("s4_four_reads", nAcc, 4);
    applyStimulus();
    applyStimulus();
    checkOutput("s4_blocked_rd", smpSRd, 0);
    checkOutput("s4_blocked_wait", smpW0, 1);
    checkOutput("s4_full", smpOut, 4);
    sRdv = 1; sRdata = 'h77;
    applyStimulus();
    checkOutput("s4_still_blocked", smpSRd, 0);
    checkOutput("s4_pop_rdv", smpRdv0, 1);
    sRdv = 0;
    applyStimulus();
    checkOutput("s4_fifth_issue", smpSRd, 1);
    checkOutput("s4_fifth_wait", smpW0, 0);
    checkOutput("s4_out_3", smpOut, 3);
    mRd = 2'b00;
    applyStimulus();
    checkOutput("s4_out_4", smpOut, 4);

    // Spurious readdatavalid sets a sticky error
    doReset();
    sRdv = 1; sRdata = 'h99;
    applyStimulus();
    checkOutput("s5_err_before", smpErr, 0);
    checkOutput("s5_no_rdv0", smpRdv0, 0);
    checkOutput("s5_no_rdv1", smpRdv1, 0);
    sRdv = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("s5_err_sticky", smpErr, 1);
    end
    doReset();
    applyStimulus();
    checkOutput("s5_err_cleared", smpErr, 0);

    // Reset mid-burst with a read outstanding discards everything
    doReset();
    mRd = 2'b10; mAddr[1] = 'h800;
    applyStimulus();
    applyStimulus();
    mRd = 2'b00; mWr = 2'b01; mBc[0] = 4; mAddr[0] = 'h900;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    rstN = 0;
    applyStimulus();
    checkOutput("s6_mid_burst_write", smpSWr, 1);
    checkOutput("s6_out_before", smpOut, 1);
    rstN = 1; mWr = 2'b00; sRdv = 1;
    applyStimulus();
    checkOutput("s6_idle_write", smpSWr, 0);
    checkOutput("s6_out_cleared", smpOut, 0);
    checkOutput("s6_no_rdv0", smpRdv0, 0);
    checkOutput("s6_no_rdv1", smpRdv1, 0);
    checkOutput("s6_m0_wait", smpW0, 1);
    sRdv = 0;
    applyStimulus();
    checkOutput("s6_err_spurious", smpErr, 1);

    // Randomized traffic: masters hold commands until accepted, slave returns data randomly
    doReset();
    slavePend = 0;
    for (int k = 0; k < 2; k++) begin mode[k] = 0; wLeft[k] = 0; firstDone[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      rstN = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < 2; k++) begin
        if (mode[k] == 0 && $urandom_range(0, 9) < 4) begin
          mode[k] = ($urandom_range(0, 1) == 0) ? 1 : 2;
          mBc[k] = BC_W'($urandom_range(0, 4));
          mAddr[k] = ADDR_W'($urandom);
          wLeft[k] = bcEff(mBc[k]);
          firstDone[k] = 0;
        end
        mRd[k] = (mode[k] == 1);
        mWr[k] = (mode[k] == 2) && (!firstDone[k] || $urandom_range(0, 3) != 0);
        mWd[k] = DATA_W'($urandom);
        mBe[k] = BE_W'($urandom);
      end
      sWait = ($urandom_range(0, 3) == 0);
      sRdv = (slavePend > 0) && ($urandom_range(0, 1) == 1);
      sRdata = DATA_W'($urandom);
      applyStimulus();
      if (!rstN) begin
        slavePend = 0;
        for (int k = 0; k < 2; k++) mode[k] = 0;
      end else begin
        if (sRdv) slavePend--;
        for (int k = 0; k < 2; k++) begin
          if (acc[k]) begin
            if (mode[k] == 1) begin
              slavePend += bcEff(mBc[k]);
              mode[k] = 0;
            end else if (mode[k] == 2) begin
              firstDone[k] = 1;
              wLeft[k]--;
              if (wLeft[k] == 0) mode[k] = 0;
            end
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 28, Avalon word address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter BC_W, default 8, burstcount width.
REQ-004 The block SHALL have parameter RD_DEPTH, default 4, maximum outstanding read commands (power of 2).

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk_i, in, 1, the single clock.
REQ-006 The block SHALL have port rst_n_i, in, 1, synchronous active-low reset.
REQ-007 For each requester mK, K=0,1, the block SHALL have these ports:
- mK_address_i, in, ADDR_W
- mK_burstcount_i, in, BC_W
- mK_write_i, in, 1
- mK_read_i, in, 1
- mK_writedata_i, in, DATA_W
- mK_byteenable_i, in, DATA_W/8
- mK_waitrequest_o, out, 1
- mK_readdata_o, out, DATA_W
- mK_readdatavalid_o, out, 1
REQ-008 The block SHALL have slave-side ports:
- s_address_o, out, ADDR_W
- s_burstcount_o, out, BC_W
- s_write_o, out, 1
- s_read_o, out, 1
- s_writedata_o, out, DATA_W
- s_byteenable_o, out, DATA_W/8
- s_waitrequest_i, in, 1
- s_readdata_i, in, DATA_W
- s_readdatavalid_i, in, 1
REQ-009 The block SHALL have port rd_outstanding_o, out, $clog2(RD_DEPTH)+1, number of read commands awaiting data.
REQ-010 The block SHALL have port err_o, out, 1, sticky flag set on readdatavalid with no outstanding read.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, CMD and WBURST.
REQ-012 In IDLE, the block SHALL latch the winner into grant and go to CMD next cycle when either requester asserts read or write; with no request, it SHALL stay in IDLE.
- Both requesting: the winner is the requester not served last (prio bit).
REQ-013 In IDLE, s_write_o and s_read_o SHALL be 0, and both mK_waitrequest_o SHALL be 1.
REQ-014 In CMD and WBURST, the s_* command outputs SHALL combinationally mirror the granted requester's inputs.
- Granted waitrequest = s_waitrequest_i.
- Non-granted waitrequest = 1.
REQ-015 A command is accepted when s_read_o or s_write_o is high and s_waitrequest_i is 0.
REQ-016 In CMD, an accepted read SHALL push {grant, burstcount} into the return FIFO, toggle prio and return to IDLE.
REQ-017 In CMD, an accepted write with burstcount 1 SHALL toggle prio and return to IDLE.
- burstcount >1: load beats_left = burstcount-1 and enter WBURST.
REQ-018 In WBURST, each accepted write beat SHALL decrement beats_left; the beat accepted with beats_left==1 SHALL toggle prio and return to IDLE.
- Grant is locked for the whole burst; the other requester is held off.
REQ-019 In CMD, when the return FIFO is full and the granted requester reads, s_read_o SHALL be 0 and the requester's waitrequest 1 until a FIFO pop frees space.
- A pop and a push in the same cycle are allowed.
REQ-020 burstcount 0 SHALL be treated as 1.
REQ-021 Read return routing:
- s_readdata_i is broadcast to both mK_readdata_o.
- mK_readdatavalid_o = s_readdatavalid_i AND (FIFO head id == K), combinational, zero latency.
REQ-022 A return beat counter SHALL count beats of the head entry; the head SHALL pop on its last beat and the counter clear.
REQ-023 s_readdatavalid_i with an empty FIFO SHALL set err_o and assert neither mK_readdatavalid_o.
REQ-024 rd_outstanding_o SHALL equal the FIFO occupancy, registered, and change by at most 1 per cycle.

Reset
REQ-025 While rst_n_i is sampled low at a clock edge, the block SHALL return to IDLE with prio favouring m0, grant=0, beats_left=0, FIFO empty, return counter 0, rd_outstanding_o=0 and err_o=0.
REQ-026 Reset mid-burst or with reads outstanding SHALL discard all state; no readdatavalid SHALL be routed until a new read is accepted.

Verification
REQ-027 The bench SHALL cover these scenarios:
- m0 and m1 both write bc=1 continuously with s_waitrequest_i=0 -> grants alternate m0,m1,m0…; each accepted beat takes 2 cycles (IDLE+CMD).
- m0 writes bc=4 while m1 requests a read -> four m0 beats land contiguously on s_*; m1_waitrequest_o stays 1 until after the 4th beat; then m1's read is issued.
- m1 reads bc=2, then m0 reads bc=3; slave returns 5 beats -> m1_readdatavalid_o on beats 1-2, m0_readdatavalid_o on beats 3-5, and rd_outstanding_o goes 1,2,1,0.
- RD_DEPTH=4 reads accepted with no data returned, then a 5th read -> s_read_o stays 0; the first return beat's pop lets the 5th read issue the next cycle.
- A readdatavalid pulse with no outstanding reads -> err_o=1 and held until reset.
- rst_n_i low during WBURST with beats_left=2 -> next cycle IDLE, s_write_o=0, rd_outstanding_o=0.
